// File: rtl/huffman_ctrl.sv
// Huffman front-end controller: counts symbol frequencies per frame, then hands them to a tree builder.
// Latency: counts visible one cycle after each accepted beat; Start_tree rises the cycle after frame close.
// Backpressure: Sym_ready is high only while counting; beats offered in any other state are not accepted.
module huffman_ctrl #(
  parameter int TIMEOUT   = 1023,
  parameter int BLOCK_MAX = 256
) (
  input  logic       Clk_in,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Sym_valid,
  output logic       Sym_ready,
  input  logic [3:0] Sym,
  input  logic       Sym_last,
  output logic [8:0] Num0,
  output logic [8:0] Num1,
  output logic [8:0] Num2,
  output logic [8:0] Num3,
  output logic [8:0] Num4,
  output logic [8:0] Num5,
  output logic [8:0] Num6,
  output logic [8:0] Num7,
  output logic [8:0] Num8,
  output logic [8:0] Num9,
  output logic       Start_tree,
  input  logic       Tree_fin,
  output logic [8:0] Sym_total,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LAUNCH,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [8:0]     num_q [10];
  logic [8:0]     num_d [10];
  logic [8:0]     total_q, total_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           sym_ready_q, sym_ready_d;
  logic           start_tree_q, start_tree_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           accept;
  logic           legal;
  logic           closing;

  assign accept = Sym_valid & sym_ready_q;
  assign legal  = (Sym <= 4'd9);

  // Next-state and counter update; every output is derived from the next state so it lands in a flop.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    total_d = total_q;
    wait_d  = wait_q;
    closing = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (Start) begin
          for (int i = 0; i < 10; i++) num_d[i] = '0;
          total_d = '0;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        if (accept) begin
          if (legal) begin
            for (int i = 0; i < 10; i++) begin
              if (Sym == 4'(i)) num_d[i] = num_q[i] + 9'd1;
            end
            total_d = total_q + 9'd1;
          end
          // Last beat and the block-full beat may coincide; either closes the frame exactly once.
          closing = Sym_last | (legal && (total_q == 9'(BLOCK_MAX - 1)));
          if (closing) begin
            wait_d  = '0;
            state_d = (total_d == 9'd0) ? S_ERR : S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        // Tree_fin takes priority over the timeout on the final waiting cycle.
        if (Tree_fin) begin
          state_d = S_DONE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    sym_ready_d  = (state_d == S_COUNT);
    start_tree_d = (state_d == S_LAUNCH);
    busy_d       = (state_d == S_COUNT) || (state_d == S_LAUNCH);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
  end

  // State, counters and registered outputs; reset clears everything immediately.
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < 10; i++) num_q[i] <= '0;
      total_q      <= '0;
      wait_q       <= '0;
      sym_ready_q  <= 1'b0;
      start_tree_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      total_q      <= total_d;
      wait_q       <= wait_d;
      sym_ready_q  <= sym_ready_d;
      start_tree_q <= start_tree_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign Sym_ready  = sym_ready_q;
  assign Start_tree = start_tree_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign Sym_total  = total_q;
  assign Num0       = num_q[0];
  assign Num1       = num_q[1];
  assign Num2       = num_q[2];
  assign Num3       = num_q[3];
  assign Num4       = num_q[4];
  assign Num5       = num_q[5];
  assign Num6       = num_q[6];
  assign Num7       = num_q[7];
  assign Num8       = num_q[8];
  assign Num9       = num_q[9];

endmodule

// File: tb/tb_huffman_ctrl.sv
// Directed testbench for huffman_ctrl: frame counting, close conditions, launch/timeout and reset.
module tb_huffman_ctrl;

  localparam int TIMEOUT   = 1023;
  localparam int BLOCK_MAX = 256;

  logic       Clk_in = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Sym_valid = 1'b0;
  logic       Sym_ready;
  logic [3:0] Sym = 4'd0;
  logic       Sym_last = 1'b0;
  logic [8:0] num [10];
  logic       Start_tree;
  logic       Tree_fin = 1'b0;
  logic [8:0] Sym_total;
  logic       Busy;
  logic       Done;
  logic       Err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk_in = ~Clk_in;

  huffman_ctrl #(.TIMEOUT(TIMEOUT), .BLOCK_MAX(BLOCK_MAX)) dut (
    .Clk_in(Clk_in), .Rst(Rst), .Start(Start),
    .Sym_valid(Sym_valid), .Sym_ready(Sym_ready), .Sym(Sym), .Sym_last(Sym_last),
    .Num0(num[0]), .Num1(num[1]), .Num2(num[2]), .Num3(num[3]), .Num4(num[4]),
    .Num5(num[5]), .Num6(num[6]), .Num7(num[7]), .Num8(num[8]), .Num9(num[9]),
    .Start_tree(Start_tree), .Tree_fin(Tree_fin), .Sym_total(Sym_total),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic start_frame();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] s, input logic l);
    Sym_valid = 1'b1;
    Sym       = s;
    Sym_last  = l;
    tick();
    Sym_valid = 1'b0;
    Sym_last  = 1'b0;
  endtask

  task automatic finish_tree();
    Tree_fin = 1'b1;
    tick();
    Tree_fin = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({Sym_ready, Start_tree, Busy, Done, Err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {Sym_ready, Start_tree, Busy, Done, Err});
    end
    n_checks++;
    if (Sym_total !== 9'd0 || num[0] !== 9'd0 || num[9] !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_counts: total=%0d num0=%0d num9=%0d expected all 0", Sym_total, num[0], num[9]);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_auto_close();
    int exp_cnt [10] = '{53, 40, 26, 14, 38, 23, 7, 12, 4, 39};
    int rem [10];
    int sent = 0;
    bit held = 1'b1;
    rem = exp_cnt;
    start_frame();
    n_checks++;
    if (Sym_ready !== 1'b1 || Busy !== 1'b1 || Err !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_enter_count: ready=%b busy=%b err=%b expected 1 1 0", Sym_ready, Busy, Err);
    end
    while (sent < 256) begin
      for (int i = 0; i < 10; i++) begin
        if (rem[i] > 0) begin
          beat(4'(i), 1'b0);
          rem[i]--;
          sent++;
        end
      end
    end
    n_checks++;
    if (Sym_ready !== 1'b0 || Start_tree !== 1'b1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_close_launch: ready=%b start_tree=%b busy=%b expected 0 1 1", Sym_ready, Start_tree, Busy);
    end
    n_checks++;
    if (Sym_total !== 9'd256) begin
      n_fail++;
      $display("FAIL auto_total: got %0d expected 256", Sym_total);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (num[i] !== 9'(exp_cnt[i])) begin
        n_fail++;
        $display("FAIL auto_num%0d: got %0d expected %0d", i, num[i], exp_cnt[i]);
      end
    end
    repeat (29) begin
      tick();
      if (Start_tree !== 1'b1 || Done !== 1'b0) held = 1'b0;
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL auto_launch_hold: start_tree/done changed while waiting, expected 1/0");
    end
    Tree_fin = 1'b1;
    tick();
    Tree_fin = 1'b0;
    n_checks++;
    if (Done !== 1'b1 || Start_tree !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_done: done=%b start_tree=%b busy=%b expected 1 0 0", Done, Start_tree, Busy);
    end
    tick();
    n_checks++;
    if (Done !== 1'b0 || Err !== 1'b0 || Sym_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_idle: done=%b err=%b ready=%b expected 0 0 0", Done, Err, Sym_ready);
    end
    n_checks++;
    if (num[0] !== 9'd53 || num[9] !== 9'd39 || Sym_total !== 9'd256) begin
      n_fail++;
      $display("FAIL auto_counts_held: num0=%0d num9=%0d total=%0d expected 53 39 256", num[0], num[9], Sym_total);
    end
  endtask

  task automatic test_all_zero();
    start_frame();
    n_checks++;
    if (Sym_total !== 9'd0 || num[0] !== 9'd0) begin
      n_fail++;
      $display("FAIL zero_cleared: total=%0d num0=%0d expected 0 0", Sym_total, num[0]);
    end
    repeat (256) beat(4'd0, 1'b0);
    n_checks++;
    if (num[0] !== 9'd256 || Start_tree !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_num0: num0=%0d start_tree=%b expected 256 1", num[0], Start_tree);
    end
    for (int i = 1; i < 10; i++) begin
      n_checks++;
      if (num[i] !== 9'd0) begin
        n_fail++;
        $display("FAIL zero_num%0d: got %0d expected 0", i, num[i]);
      end
    end
    finish_tree();
  endtask

  task automatic test_coincide();
    start_frame();
    repeat (255) beat(4'd9, 1'b0);
    n_checks++;
    if (Sym_ready !== 1'b1 || Sym_total !== 9'd255) begin
      n_fail++;
      $display("FAIL coin_pre: ready=%b total=%0d expected 1 255", Sym_ready, Sym_total);
    end
    beat(4'd9, 1'b1);
    n_checks++;
    if (Start_tree !== 1'b1 || num[9] !== 9'd256 || Err !== 1'b0 || Sym_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_close: start_tree=%b num9=%0d err=%b ready=%b expected 1 256 0 0", Start_tree, num[9], Err, Sym_ready);
    end
    tick();
    n_checks++;
    if (Start_tree !== 1'b1 || Err !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_single: start_tree=%b err=%b done=%b expected 1 0 0", Start_tree, Err, Done);
    end
    finish_tree();
  endtask

  task automatic test_illegal();
    bit never = 1'b1;
    start_frame();
    beat(4'd12, 1'b1);
    n_checks++;
    if (Err !== 1'b1 || Start_tree !== 1'b0 || Sym_ready !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_err: err=%b start_tree=%b ready=%b busy=%b expected 1 0 0 0", Err, Start_tree, Sym_ready, Busy);
    end
    Tree_fin = 1'b1;
    repeat (4) begin
      tick();
      if (Start_tree !== 1'b0 || Err !== 1'b1 || Done !== 1'b0) never = 1'b0;
    end
    Tree_fin = 1'b0;
    n_checks++;
    if (!never) begin
      n_fail++;
      $display("FAIL ill_hold: start_tree/err/done left 0/1/0 while in error");
    end
    start_frame();
    n_checks++;
    if (Err !== 1'b0 || Sym_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_restart: err=%b ready=%b expected 0 1", Err, Sym_ready);
    end
    beat(4'd15, 1'b0);
    beat(4'd3, 1'b0);
    beat(4'd10, 1'b1);
    n_checks++;
    if (Sym_total !== 9'd1 || num[3] !== 9'd1 || Start_tree !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_discard: total=%0d num3=%0d start_tree=%b expected 1 1 1", Sym_total, num[3], Start_tree);
    end
    finish_tree();
  endtask

  task automatic test_timeout();
    bit waiting = 1'b1;
    start_frame();
    beat(4'd5, 1'b1);
    n_checks++;
    if (Start_tree !== 1'b1) begin
      n_fail++;
      $display("FAIL to_launch: start_tree=%b expected 1", Start_tree);
    end
    repeat (TIMEOUT - 1) begin
      tick();
      if (Start_tree !== 1'b1 || Err !== 1'b0) waiting = 1'b0;
    end
    n_checks++;
    if (!waiting) begin
      n_fail++;
      $display("FAIL to_early: error or drop before %0d cycles", TIMEOUT);
    end
    tick();
    n_checks++;
    if (Err !== 1'b1 || Start_tree !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err: err=%b start_tree=%b busy=%b done=%b expected 1 0 0 0", Err, Start_tree, Busy, Done);
    end
  endtask

  task automatic test_fin_on_timeout();
    start_frame();
    beat(4'd6, 1'b1);
    repeat (TIMEOUT - 1) tick();
    Tree_fin = 1'b1;
    tick();
    Tree_fin = 1'b0;
    n_checks++;
    if (Done !== 1'b1 || Err !== 1'b0 || Start_tree !== 1'b0) begin
      n_fail++;
      $display("FAIL fin_wins: done=%b err=%b start_tree=%b expected 1 0 0", Done, Err, Start_tree);
    end
    tick();
    n_checks++;
    if (Done !== 1'b0) begin
      n_fail++;
      $display("FAIL fin_pulse: done=%b expected 0", Done);
    end
  endtask

  task automatic test_launch_ignores();
    start_frame();
    beat(4'd2, 1'b0);
    beat(4'd2, 1'b0);
    beat(4'd7, 1'b1);
    Sym_valid = 1'b1;
    Sym       = 4'd2;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    n_checks++;
    if (Sym_ready !== 1'b0 || Start_tree !== 1'b1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_state: ready=%b start_tree=%b busy=%b expected 0 1 1", Sym_ready, Start_tree, Busy);
    end
    repeat (3) tick();
    Sym_valid = 1'b0;
    n_checks++;
    if (num[2] !== 9'd2 || num[7] !== 9'd1 || Sym_total !== 9'd3) begin
      n_fail++;
      $display("FAIL ign_counts: num2=%0d num7=%0d total=%0d expected 2 1 3", num[2], num[7], Sym_total);
    end
    finish_tree();
  endtask

  task automatic test_reset_mid_launch();
    start_frame();
    beat(4'd4, 1'b0);
    beat(4'd9, 1'b1);
    repeat (5) tick();
    #2;
    Rst = 1'b1;
    #1;
    n_checks++;
    if (Start_tree !== 1'b0 || Busy !== 1'b0 || Sym_total !== 9'd0 || num[4] !== 9'd0 || num[9] !== 9'd0) begin
      n_fail++;
      $display("FAIL rst_async: start_tree=%b busy=%b total=%0d num4=%0d num9=%0d expected all 0",
               Start_tree, Busy, Sym_total, num[4], num[9]);
    end
    tick();
    Rst = 1'b0;
    start_frame();
    n_checks++;
    if (Sym_ready !== 1'b1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first_start: ready=%b busy=%b expected 1 1", Sym_ready, Busy);
    end
    beat(4'd1, 1'b1);
    n_checks++;
    if (num[1] !== 9'd1 || Start_tree !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recount: num1=%0d start_tree=%b expected 1 1", num[1], Start_tree);
    end
    finish_tree();
  endtask

  initial begin
    test_reset();
    test_auto_close();
    test_all_zero();
    test_coincide();
    test_illegal();
    test_timeout();
    test_fin_on_timeout();
    test_launch_ignores();
    test_reset_mid_launch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_ctrl.md
HUFFMAN_CTRL -- requirements
Module: huffman_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1023, max cycles to wait for Tree_fin after Start_tree rises.
REQ-002 Parameter BLOCK_MAX, default 256, max counted symbols per frame; fixed so every count fits 9 bits.
REQ-003 Clk_in  in  1  single clock, all state on rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 Start  in  1  begin new frame; sampled only in IDLE or ERR.
REQ-006 Sym_valid  in  1  symbol beat valid.
REQ-007 Sym_ready  out  1  symbol beat accepted when Sym_valid & Sym_ready.
REQ-008 Sym  in  4  symbol index; 0..9 legal.
REQ-009 Sym_last  in  1  final beat of frame, qualified by the accept.
REQ-010 Num0..Num9  out  9 each  per-symbol frequency counts, fed to the tree builder.
REQ-011 Start_tree  out  1  tree-builder start level.
REQ-012 Tree_fin  in  1  tree-builder completion.
REQ-013 Sym_total  out  9  counted legal symbols in the current frame.
REQ-014 Busy  out  1  high in COUNT or LAUNCH.
REQ-015 Done  out  1  one-cycle pulse on successful tree build.
REQ-016 Err  out  1  high in ERR.

Function
REQ-017 States SHALL be IDLE, COUNT, LAUNCH, DONE, ERR; all outputs SHALL be registered.
REQ-018 IDLE/ERR with Start=1 SHALL clear Num0..Num9, Sym_total and Err, and enter COUNT next cycle; Start in any other state SHALL be ignored.
REQ-019 Sym_ready SHALL be 1 only in COUNT.
REQ-020 An accepted legal Sym (0..9) SHALL increment NumSym and Sym_total by 1, visible the next cycle.
REQ-021 An accepted Sym 10..15 SHALL be discarded with no counter change; its Sym_last still closes the frame.
REQ-022 The frame SHALL close on an accepted Sym_last, or on the accept that brings Sym_total to BLOCK_MAX; Sym_ready SHALL drop the next cycle.
REQ-023 If Sym_last and the BLOCK_MAX accept coincide, the frame SHALL close once with no double action.
REQ-024 Close with Sym_total=0 SHALL go to ERR without asserting Start_tree.
REQ-025 Close with Sym_total>0 SHALL enter LAUNCH next cycle, with Start_tree=1 from that cycle.
REQ-026 Num0..Num9 SHALL stay constant from LAUNCH until the next accepted Start.
REQ-027 In LAUNCH a wait counter SHALL count cycles from 0.
REQ-028 In LAUNCH, Tree_fin=1 SHALL move the FSM to DONE, with Start_tree=0 from that cycle.
REQ-029 If the wait counter reaches TIMEOUT without Tree_fin, the FSM SHALL enter ERR with Start_tree=0.
REQ-030 Tree_fin on the TIMEOUT cycle SHALL win, going to DONE.
REQ-031 DONE SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-032 Tree_fin outside LAUNCH SHALL be ignored.
REQ-033 ERR SHALL hold Err=1 until the next accepted Start or Rst.

Reset
REQ-034 Rst=1 SHALL immediately force IDLE and zero all outputs, counters and the wait counter, including mid-COUNT or mid-LAUNCH; Start_tree SHALL fall asynchronously.
REQ-035 After Rst release, the first Start SHALL be honoured on the first rising edge.

Verification
REQ-036 Start; 256 legal beats with counts 53,40,26,14,38,23,7,12,4,39 for symbols 0..9, no Sym_last -> frame auto-closes; Num0..9 equal those counts; Sym_total=256; Start_tree rises next cycle; Tree_fin 30 cycles later -> Done one cycle, then IDLE.
REQ-037 Start; 256 beats of Sym=0 -> Num0=256, Num1..9=0, LAUNCH entered.
REQ-038 Start; one beat Sym=12 with Sym_last -> ERR, Err=1, Start_tree never asserted; next Start clears Err.
REQ-039 Valid frame, Tree_fin held 0 -> Err=1 exactly TIMEOUT cycles after Start_tree rose; Start_tree=0.
REQ-040 Sym_valid=1 during LAUNCH -> Sym_ready=0, counts unchanged; Start pulsed during LAUNCH -> ignored.
REQ-041 Rst asserted 5 cycles into LAUNCH -> Start_tree, Busy, Num0..9 and Sym_total are 0 before the next clock edge.
